// File: rtl/sha3_msg_feeder.sv
// rtl/sha3_msg_feeder.sv - byte-stream to SHA3-256 Avalon-MM block feeder with digest readback
// Optional poll timeout: define SHA3_FEEDER_TIMEOUT_EN.
module sha3_msg_feeder #(
    parameter int unsigned RATE_WORDS     = 34,
    parameter int unsigned DIGEST_WORDS   = 8,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] dig_data,
    output logic        dig_valid,
    output logic        dig_last,
    input  logic        dig_ready,
    output logic        err
);
    localparam logic [7:0] BLK_BYTES = 8'(RATE_WORDS * 4);
    localparam logic [5:0] LAST_WORD = 6'(RATE_WORDS - 1);
    localparam logic [2:0] LAST_DIG  = 3'(DIGEST_WORDS - 1);
    localparam logic [7:0] CTRL_ADDR = 8'h40;
    localparam logic [7:0] STAT_ADDR = 8'h41;
    localparam logic [7:0] DIG_ADDR  = 8'h48;

    if (RATE_WORDS * 4 > 255 || DIGEST_WORDS > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_params
        $error("sha3_msg_feeder: unsupported parameter set");
    end

    typedef enum logic [2:0] {IDLE, FILL, WR, PAD, START, POLL, DRD, DOUT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        pad_q, pad_d;
    logic        need06_q, need06_d;
    logic        final_q, final_d;
    logic [2:0]  dig_idx_q, dig_idx_d;
    logic [7:0]  addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] dig_data_q, dig_data_d;
    logic        dig_valid_q, dig_valid_d;
    logic        dig_last_q, dig_last_d;
    logic [31:0] pw;
    logic        timeout_hit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            word_q      <= '0;
            pad_q       <= 1'b0;
            need06_q    <= 1'b0;
            final_q     <= 1'b0;
            dig_idx_q   <= '0;
            addr_q      <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            dig_data_q  <= '0;
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            pad_q       <= pad_d;
            need06_q    <= need06_d;
            final_q     <= final_d;
            dig_idx_q   <= dig_idx_d;
            addr_q      <= addr_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            dig_data_q  <= dig_data_d;
            dig_valid_q <= dig_valid_d;
            dig_last_q  <= dig_last_d;
        end
    end

    // Bus states spend one idle cycle issuing the command, then hold it until waitrequest drops.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        pad_d       = pad_q;
        need06_d    = need06_q;
        final_d     = final_q;
        dig_idx_d   = dig_idx_q;
        addr_d      = addr_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        dig_data_d  = dig_data_q;
        dig_valid_d = dig_valid_q;
        dig_last_d  = dig_last_q;
        pw          = '0;
        case (state_q)
            IDLE: state_d = FILL;
            FILL: begin
                if (s_valid) begin
                    word_d[{cnt_q[1:0], 3'b000} +: 8] = s_data;
                    cnt_d = cnt_q + 8'd1;
                    if (s_last) begin
                        pad_d    = 1'b1;
                        need06_d = 1'b1;
                    end
                    if (cnt_q[1:0] == 2'd3)
                        state_d = WR;
                    else if (s_last)
                        state_d = PAD;
                end
            end
            WR: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = {2'b00, cnt_q[7:2] - 6'd1};
                    wdata_d = word_q;
                end else if (!avm_waitrequest) begin
                    wr_d = 1'b0;
                    if (cnt_q == BLK_BYTES)
                        state_d = START;
                    else if (pad_q)
                        state_d = PAD;
                    else
                        state_d = FILL;
                end
            end
            PAD: begin
                // Keep message bytes below the fill position, then 0x06 once, then zeros.
                for (int l = 0; l < 4; l++) begin
                    if (l < int'(cnt_q[1:0]))
                        pw[8*l +: 8] = word_q[8*l +: 8];
                    else if (l == int'(cnt_q[1:0]) && need06_q)
                        pw[8*l +: 8] = 8'h06;
                end
                if (cnt_q[7:2] == LAST_WORD)
                    pw[31:24] = pw[31:24] | 8'h80;
                word_d   = pw;
                need06_d = 1'b0;
                final_d  = 1'b1;
                cnt_d    = {cnt_q[7:2] + 6'd1, 2'b00};
                state_d  = WR;
            end
            START: begin
                if (!wr_q) begin
                    wr_d    = 1'b1;
                    addr_d  = CTRL_ADDR;
                    wdata_d = {30'b0, final_q, 1'b1};
                end else if (!avm_waitrequest) begin
                    wr_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = POLL;
                end
            end
            POLL: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = STAT_ADDR;
                end else if (!avm_waitrequest) begin
                    rd_d = 1'b0;
                    if (final_q) begin
                        if (avm_readdata[1]) begin
                            dig_idx_d = '0;
                            state_d   = DRD;
                        end
                    end else if (!avm_readdata[0]) begin
                        // A message that filled its block exactly still owes a padding block.
                        state_d = pad_q ? PAD : FILL;
                    end
                end
            end
            DRD: begin
                if (!rd_q) begin
                    rd_d   = 1'b1;
                    addr_d = DIG_ADDR + {5'b0, dig_idx_q};
                end else if (!avm_waitrequest) begin
                    rd_d        = 1'b0;
                    dig_data_d  = avm_readdata;
                    dig_valid_d = 1'b1;
                    dig_last_d  = (dig_idx_q == LAST_DIG);
                    state_d     = DOUT;
                end
            end
            DOUT: begin
                if (dig_ready) begin
                    dig_valid_d = 1'b0;
                    dig_last_d  = 1'b0;
                    if (dig_idx_q == LAST_DIG) begin
                        dig_idx_d = '0;
                        cnt_d     = '0;
                        pad_d     = 1'b0;
                        need06_d  = 1'b0;
                        final_d   = 1'b0;
                        state_d   = FILL;
                    end else begin
                        dig_idx_d = dig_idx_q + 3'd1;
                        state_d   = DRD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (timeout_hit) begin
            rd_d     = 1'b0;
            cnt_d    = '0;
            pad_d    = 1'b0;
            need06_d = 1'b0;
            final_d  = 1'b0;
            state_d  = FILL;
        end
    end

`ifdef SHA3_FEEDER_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt_q;
    logic            err_q;

    assign timeout_hit = (state_q == POLL) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            to_cnt_q <= (state_q == POLL) ? to_cnt_q + TO_W'(1) : '0;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    assign s_ready       = (state_q == FILL);
    assign avm_address   = addr_q;
    assign avm_read      = rd_q;
    assign avm_write     = wr_q;
    assign avm_writedata = wdata_q;
    assign dig_data      = dig_data_q;
    assign dig_valid     = dig_valid_q;
    assign dig_last      = dig_last_q;
endmodule

// File: tb/tb_sha3_msg_feeder.sv
// tb/tb_sha3_msg_feeder.sv - scoreboard bench for sha3_msg_feeder with an Avalon slave model
module tb_sha3_msg_feeder;
    localparam int TO = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  s_data;
    logic        s_valid, s_last, s_ready;
    logic [7:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic [31:0] dig_data;
    logic        dig_valid, dig_last, dig_ready;
    logic        err;

    sha3_msg_feeder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .dig_data(dig_data), .dig_valid(dig_valid), .dig_last(dig_last),
        .dig_ready(dig_ready), .err(err)
    );

    always #5 clk = ~clk;

    logic [77:0] outs_w;
    assign outs_w = {s_ready, avm_read, avm_write, avm_address, avm_writedata,
                     dig_valid, dig_last, dig_data, err};

    int total = 0;
    int bad   = 0;

    logic [39:0] exp_wr[$];
    logic [32:0] exp_dig[$];
    logic [7:0]  msg[$];
    logic [31:0] dig_mem [8] = '{32'h3a985da7, 32'h4fe225b2, 32'h045c172d, 32'h6bd390bd,
                                 32'h855f086e, 32'h3e9d525b, 32'h46bfe245, 32'h11431532};

    int   stall_cfg = 0, rdy_mode = 0, poll_busy = 2, busy_polls = 0, wr_count = 0;
    bit   stuck_busy = 0, gap_en = 0, dig_seen = 0;
    logic final_blk = 1'b0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave, digest sink and protocol monitor, all evaluated mid-cycle.
    initial begin
        bit          in_xfer;
        bit          dig_hold;
        int          left;
        logic [41:0] held_cmd;
        logic [31:0] held_dig;
        logic [39:0] ew;
        logic [32:0] ed;
        in_xfer = 0; dig_hold = 0; left = 0; held_cmd = '0; held_dig = '0;
        avm_waitrequest = 1'b0; avm_readdata = '0; dig_ready = 1'b0;
        forever begin
            @(negedge clk);
            dig_ready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (reset) begin
                in_xfer = 0; dig_hold = 0; avm_waitrequest = 1'b0;
                continue;
            end
            if (dig_hold)
                chk("dig_hold", {dig_valid, dig_data}, {1'b1, held_dig});
            dig_hold = 0;
            if (dig_valid) begin
                dig_seen = 1;
                if (dig_ready) begin
                    if (exp_dig.size() == 0) chk("dig_unexpected", dig_valid, 1'b0);
                    else begin
                        ed = exp_dig.pop_front();
                        chk("dig_word", {dig_last, dig_data}, ed);
                    end
                end else begin
                    dig_hold = 1;
                    held_dig = dig_data;
                end
            end
            if (avm_read || avm_write) begin
                chk("rw_exclusive", avm_read & avm_write, 1'b0);
                if (!in_xfer) begin
                    in_xfer  = 1;
                    left     = stall_cfg;
                    held_cmd = {avm_read, avm_write, avm_address, avm_writedata};
                end else begin
                    chk("cmd_hold", {avm_read, avm_write, avm_address, avm_writedata}, held_cmd);
                end
                if (left > 0) begin
                    left--;
                    avm_waitrequest = 1'b1;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_xfer = 0;
                    if (avm_write) begin
                        wr_count++;
                        if (exp_wr.size() == 0) chk("wr_unexpected", avm_write, 1'b0);
                        else begin
                            ew = exp_wr.pop_front();
                            chk("wr", {avm_address, avm_writedata}, ew);
                        end
                        if (avm_address == 8'h40 && avm_writedata[0]) begin
                            busy_polls = poll_busy;
                            final_blk  = avm_writedata[1];
                        end
                    end else if (avm_address == 8'h41) begin
                        if (stuck_busy) avm_readdata = 32'h1;
                        else if (busy_polls > 0) begin
                            busy_polls--;
                            avm_readdata = 32'h1;
                        end else avm_readdata = {30'b0, final_blk, 1'b0};
                    end else if (avm_address[7:3] == 5'b01001) begin
                        avm_readdata = dig_mem[avm_address[2:0]];
                    end else begin
                        avm_readdata = 32'hDEAD_BEEF;
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                in_xfer = 0;
            end
        end
    end

    task automatic load_abc();
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
    endtask

    task automatic load_rand(input int n);
        msg.delete();
        for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
    endtask

    // Independent padding model: pad10*1 with domain byte 0x06 over 136-byte blocks.
    task automatic push_expect(input bit with_dig);
        int len = msg.size();
        int nb  = len / 136 + 1;
        logic [7:0] p [];
        p = new[nb * 136];
        foreach (p[i]) p[i] = 8'h00;
        foreach (msg[i]) p[i] = msg[i];
        p[len] = 8'h06;
        p[nb*136-1] = p[nb*136-1] | 8'h80;
        for (int b = 0; b < nb; b++) begin
            for (int w = 0; w < 34; w++) begin
                int o = b * 136 + w * 4;
                exp_wr.push_back({8'(w), p[o+3], p[o+2], p[o+1], p[o]});
            end
            exp_wr.push_back({8'h40, (b == nb - 1) ? 32'h3 : 32'h1});
        end
        if (with_dig)
            for (int k = 0; k < 8; k++) exp_dig.push_back({(k == 7), dig_mem[k]});
    endtask

    task automatic drive_msg();
        for (int i = 0; i < msg.size(); i++) begin
            int guard = 0;
            @(negedge clk);
            if (gap_en && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_data  = msg[i];
            s_last  = (i == msg.size() - 1);
            while (!s_ready && guard < 2000) begin
                @(negedge clk);
                guard++;
            end
            if (!s_ready) begin
                chk("s_ready_wait", s_ready, 1'b1);
                break;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_dig.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drained", {32'(exp_wr.size()), 32'(exp_dig.size())}, 64'd0);
        repeat (3) @(negedge clk);
        chk("back_to_fill", s_ready, 1'b1);
    endtask

    task automatic run(input bit abc, input int n);
        if (abc) load_abc(); else load_rand(n);
        push_expect(1'b1);
        drive_msg();
        wait_done(20000);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, n;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0; reset = 1'b0;
        #1 reset = 1'b1;
        #2 chk("reset_outputs", outs_w, 78'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("fill_after_reset", s_ready, 1'b1);

        run(1'b1, 0);
        n0 = wr_count;
        run(1'b0, 136);
        chk("writes_136", wr_count - n0, 70);
        run(1'b0, 135);
        run(1'b0, 4);
        gap_en = 1; rdy_mode = 1; poll_busy = 3;
        run(1'b0, 7);
        run(1'b0, 272);

        stall_cfg = 5;
        run(1'b1, 0);
        run(1'b0, 140);
        stall_cfg = 0; gap_en = 0; rdy_mode = 0; poll_busy = 2;

        stuck_busy = 1;
        load_abc(); push_expect(1'b1); drive_msg();
        n = 0;
        while (!(avm_read && avm_address == 8'h41) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("poll_reached", {avm_read, avm_address}, {1'b1, 8'h41});
        repeat (3) @(negedge clk);
        chk("poll_writes_done", exp_wr.size(), 0);
        #2 reset = 1'b1;
        #1 chk("reset_in_poll", outs_w, 78'd0);
        exp_dig.delete();
        stuck_busy = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        run(1'b1, 0);

`ifdef SHA3_FEEDER_TIMEOUT_EN
        stuck_busy = 1;
        dig_seen = 0;
        load_abc(); push_expect(1'b0); drive_msg();
        n = 0;
        while (!(avm_read && avm_address == 8'h41) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!err && n < TO + 1000) begin
            @(negedge clk);
            n++;
        end
        chk("err_set", err, 1'b1);
        chk("err_latency", (n >= TO - 8) && (n <= TO + 8), 1'b1);
        repeat (3) @(negedge clk);
        chk("s_ready_after_timeout", s_ready, 1'b1);
        chk("no_digest_after_timeout", dig_seen, 1'b0);
        chk("timeout_writes_done", exp_wr.size(), 0);
        stuck_busy = 0;
`else
        chk("err_tied_low", err, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
